div256: RTL and testbench
=========================

# div256

Sequential restoring divider: a 256-bit dividend divided by a 128-bit divisor gives a 256-bit quotient and a 128-bit remainder. It produces one quotient bit per clock. It is the inverse companion of the 128x128 multiplier `mux128`, so `yout` from the multiplier can be fed back as the dividend to recover an operand. It uses the same level `start` / pulsed `done` handshake as the multiplier, so both blocks can share one controller.

## Interface
- `DW`, 256, dividend and quotient width.
- `VW`, 128, divisor and remainder width; `VW` < `DW`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; level-sensitive, sampled only in IDLE.
- `ain`  in  DW  dividend; sampled on the accepting edge only.
- `bin`  in  VW  divisor; sampled on the accepting edge only.
- `quo`  out  DW  quotient, registered.
- `rem`  out  VW  remainder, registered.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; `quo` and `rem` are valid from this cycle.
- `err`  out  1  divide-by-zero flag; updated together with `done` (see Configuration).

## Operation
- States:
  - IDLE: on `start`=1, latch `ain`/`bin`, clear the partial remainder and the iteration count `cnt`, and go to RUN.
  - RUN: perform one iteration per edge. On the edge where `cnt`==DW-1, load `quo`/`rem` and go to DONE.
  - DONE: `done`=1 for this single cycle, then go to ARM.
  - ARM: wait for `start`=0, then go to IDLE.
  - ARM exists so that a `start` held high for a long time yields exactly one division.
- Iteration (restoring division):
  - `r` is a VW+1-bit partial remainder.
  - Shift: r = {r[VW-1:0], next dividend MSB}.
  - If r >= {1'b0,divisor}: r = r - divisor and the quotient bit is 1; otherwise the quotient bit is 0.
  - Quotient bits shift in MSB-first.
- Arithmetic: unsigned only, exact. `quo`*`bin`+`rem` == `ain` and `rem` < `bin` whenever `bin`≠0.
- Divisor zero: the algorithm naturally gives `quo`=all ones and `rem`=`ain[VW-1:0]`. These values are required in both builds.
- `quo`, `rem` and `err` hold their values from the DONE cycle until the next DONE; they do not change during RUN.
- `start` and operand changes during RUN, DONE or ARM are ignored.
- Reset (any state, including mid-RUN): the state machine returns to IDLE and all outputs go to 0. Any in-flight division is discarded with no `done` pulse.
- Reset values: `quo`=0, `rem`=0, `busy`=0, `done`=0, `err`=0.

## Timing
- Edge E0 samples `start`=1 in IDLE; `busy` goes high after E0.
- Edges E1..E(DW) are the DW iterations. After E(DW): `busy`=0, `done`=1, and `quo`/`rem` are valid.
- `done` deasserts after E(DW+1). Total latency is DW edges after acceptance (256 for the defaults).
- Minimum spacing between results: if `start` is low at E(DW+1), ARM sees it at E(DW+2) and IDLE can accept at E(DW+3).
- `busy` and `done` are never high in the same cycle.

## Configuration
- `DIV256_DBZ_EN` defined (divide-by-zero fast path):
  - A zero `bin` at E0 skips RUN: go straight to DONE with `quo`=all ones, `rem`=`ain[VW-1:0]`, `err`=1.
  - `done` rises after E1.
  - `err`=0 for every non-zero divisor.
- `DIV256_DBZ_EN` undefined:
  - `err` is tied to 0.
  - A zero divisor runs the full DW iterations and produces the same `quo`/`rem` values as above.

## Test plan
- Basic division: after reset, `ain`=256'd1000, `bin`=128'd7, `start`=1. Expect `done` exactly 256 cycles after acceptance with `quo`=142, `rem`=6, `err`=0.
- Round trip with the multiplier:
  - Set `ain` = product of 128'h0111_0000_0000_0000_0000_0000_1010_0000 and 128'h0000_0000_0000_1111_1111_0000_0000_0000, with `bin` = the second factor.
  - Expect `quo` = the first factor and `rem`=0.
- Held start: hold `start` high for 1000 cycles. Expect exactly one `done` pulse. Then drop `start` for 2 cycles and raise it again; expect a second `done` 256 cycles after the new acceptance.
- Divide by zero: `ain`=256'h1_0000_0000_0000_0000_0000_0000_0000_0005, `bin`=0.
  - Both builds: `quo`=all ones, `rem`=128'd5.
  - With `DIV256_DBZ_EN`: `done` one cycle after acceptance, `err`=1.
  - Without it: `done` after 256 cycles, `err`=0.
- Reset mid-operation: assert `rst` 100 cycles into RUN. Expect all outputs to go to 0 immediately with no `done` pulse. A following request with `ain`=256'd81, `bin`=128'd9 yields `quo`=9, `rem`=0.
- Edge operands:
  - `ain`=all ones, `bin`=1: expect `quo`=all ones, `rem`=0.
  - `ain`=5, `bin`=all ones: expect `quo`=0, `rem`=5.

Source files
------------

// File: rtl/div256_if.sv
// -----------------------------------------------------------------------------
// div256_if
// Purpose : Groups the request/result signals of the div256 sequential divider
//           so that a controller (master) and the divider (slave) can be
//           connected with one port. Uses the same start/done handshake as the
//           mux128 multiplier, so one controller can drive both blocks.
// Parameters:
//   DW    dividend / quotient width
//   VW    divisor / remainder width (VW < DW)
// Signals:
//   start  master->slave  level request, sampled only while the divider is idle
//   ain    master->slave  dividend, sampled on the accepting edge
//   bin    master->slave  divisor, sampled on the accepting edge
//   quo    slave->master  registered quotient
//   rem    slave->master  registered remainder
//   busy   slave->master  high while iterating
//   done   slave->master  one-cycle pulse, quo/rem/err valid from this cycle
//   err    slave->master  divide-by-zero flag (only with DIV256_DBZ_EN)
// -----------------------------------------------------------------------------
interface div256_if #(
   parameter int DW = 256,
   parameter int VW = 128
);
   logic          start;
   logic [DW-1:0] ain;
   logic [VW-1:0] bin;
   logic [DW-1:0] quo;
   logic [VW-1:0] rem;
   logic          busy;
   logic          done;
   logic          err;

   // Controller side: issues requests, observes results
   modport master (
      output start, ain, bin,
      input  quo, rem, busy, done, err
   );

   // Divider side: accepts requests, produces results
   modport slave (
      input  start, ain, bin,
      output quo, rem, busy, done, err
   );
endinterface

// File: rtl/div256.sv
// -----------------------------------------------------------------------------
// div256
// Purpose : Sequential restoring divider. A DW-bit dividend is divided by a
//           VW-bit divisor, one quotient bit per clock, MSB first, giving a
//           DW-bit quotient and a VW-bit remainder (unsigned, exact).
//           Companion of the mux128 multiplier: its product can be fed back as
//           the dividend to recover an operand.
// Ports:
//   clk   in   system clock, all state updates on the rising edge
//   rst   in   asynchronous active-high reset
//   bus   slave modport of div256_if (start/ain/bin in, quo/rem/busy/done/err out)
// Configuration macro:
//   DIV256_DBZ_EN  when defined, a zero divisor skips the iterations: done
//                  rises one edge after acceptance with err=1. When undefined,
//                  err is always 0 and a zero divisor runs the full DW
//                  iterations. Both builds give quo=all ones, rem=ain[VW-1:0]
//                  for a zero divisor.
// Timing:
//   accept at E0, iterations at E1..E(DW), done high for the cycle after E(DW).
//   The ARM state waits for start to drop so a held start yields one result.
// -----------------------------------------------------------------------------
module div256 #(
   parameter int DW = 256,
   parameter int VW = 128
) (
   input  logic    clk,
   input  logic    rst,
   div256_if.slave bus
);

   localparam int CW = $clog2(DW);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE,
      S_ARM
   } state_t;

   state_t r_state;
   state_t w_nextState;

   // The dividend register doubles as the quotient accumulator: each
   // iteration shifts out one dividend bit at the top and shifts the new
   // quotient bit in at the bottom, so after DW steps it holds the quotient.
   logic [DW-1:0] r_dvd;
   logic [VW-1:0] r_dvs;
   logic [VW:0]   r_part;
   logic [CW-1:0] r_cnt;
   logic [DW-1:0] r_quo;
   logic [VW-1:0] r_rem;
   logic          r_err;

   logic [VW:0]   w_shift;
   logic          w_ge;
   logic [VW:0]   w_nextPart;
   logic [DW-1:0] w_nextDvd;
   logic          w_lastIter;
   logic          w_dbzHit;

`ifdef DIV256_DBZ_EN
   logic          r_dbz;

   // Remember at acceptance whether the divisor was zero, so the single
   // RUN cycle that follows can publish the fast-path result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dbz <= 1'b0;
      end else if (r_state == S_IDLE && bus.start) begin
         r_dbz <= (bus.bin == '0);
      end
   end

   assign w_dbzHit = r_dbz;
`else
   assign w_dbzHit = 1'b0;
`endif

   // One restoring step: bring in the next dividend MSB, then subtract the
   // divisor if it fits. With a zero divisor the compare always succeeds,
   // which naturally yields an all-ones quotient and rem = ain[VW-1:0].
   always_comb begin
      w_shift    = {r_part[VW-1:0], r_dvd[DW-1]};
      w_ge       = (w_shift >= {1'b0, r_dvs});
      w_nextPart = w_ge ? (w_shift - {1'b0, r_dvs}) : w_shift;
      w_nextDvd  = {r_dvd[DW-2:0], w_ge};
      w_lastIter = (r_cnt == CW'(DW-1));
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. ARM blocks re-acceptance until start has been seen low.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_nextState = S_RUN;
            end
         end
         S_RUN: begin
            if (w_dbzHit || w_lastIter) begin
               w_nextState = S_DONE;
            end
         end
         S_DONE: begin
            w_nextState = S_ARM;
         end
         S_ARM: begin
            if (!bus.start) begin
               w_nextState = S_IDLE;
            end
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   // Datapath: latch operands on acceptance, iterate in RUN, and publish the
   // result registers only on the final edge so they hold steady until the
   // next result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dvd  <= '0;
         r_dvs  <= '0;
         r_part <= '0;
         r_cnt  <= '0;
         r_quo  <= '0;
         r_rem  <= '0;
         r_err  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_dvd  <= bus.ain;
                  r_dvs  <= bus.bin;
                  r_part <= '0;
                  r_cnt  <= '0;
               end
            end
            S_RUN: begin
               if (w_dbzHit) begin
                  r_quo <= '1;
                  r_rem <= r_dvd[VW-1:0];
                  r_err <= 1'b1;
               end else begin
                  r_dvd  <= w_nextDvd;
                  r_part <= w_nextPart;
                  r_cnt  <= r_cnt + 1'b1;
                  if (w_lastIter) begin
                     r_quo <= w_nextDvd;
                     r_rem <= w_nextPart[VW-1:0];
                     r_err <= 1'b0;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.quo  = r_quo;
   assign bus.rem  = r_rem;
   assign bus.err  = r_err;
   assign bus.busy = (r_state == S_RUN);
   assign bus.done = (r_state == S_DONE);

endmodule

// File: tb/tb_div256.sv
// -----------------------------------------------------------------------------
// tb_div256
// Purpose : Self-checking bench for div256. A table of directed divisions with
//           hand-computed results is applied in a loop; hand-written sequences
//           cover the held-start, reset-mid-run and zero-divisor cases.
//           Expectations for the zero-divisor case follow DIV256_DBZ_EN.
// -----------------------------------------------------------------------------
module tb_div256;

   localparam int DW = 256;
   localparam int VW = 128;

   logic clk;
   logic rst;

   int testsRun;
   int testsFailed;

   div256_if #(.DW(DW), .VW(VW)) bus ();

   div256 #(.DW(DW), .VW(VW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [DW-1:0] ain;
      logic [VW-1:0] bin;
      logic [DW-1:0] quo;
      logic [VW-1:0] rem;
   } vec_t;

   vec_t vecs[8];

   // Compare one value and report on mismatch
   task automatic checkOutput(input string name, input logic [DW-1:0] act,
                              input logic [DW-1:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue one request, scramble the operands after acceptance (they must be
   // ignored), wait a bounded time for done, then let the FSM return to IDLE.
   task automatic applyStimulus(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                output int lat, output logic busyE0,
                                output logic overlap);
      @(negedge clk);
      bus.ain   = a;
      bus.bin   = b;
      bus.start = 1'b1;
      lat       = -1;
      busyE0    = 1'b0;
      overlap   = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (i == 0) begin
            busyE0 = bus.busy;
            bus.ain = ~a;
            bus.bin = ~b;
         end
         if (bus.busy && bus.done) overlap = 1'b1;
         if (bus.done) begin
            lat = i;
            break;
         end
      end
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      logic [VW-1:0] facA;
      logic [VW-1:0] facB;
      int            lat;
      int            expLat;
      logic          busyE0;
      logic          overlap;
      logic          expErr;
      int            doneCount;

      testsRun    = 0;
      testsFailed = 0;

      facA = 128'h0111_0000_0000_0000_0000_0000_1010_0000;
      facB = 128'h0000_0000_0000_1111_1111_0000_0000_0000;

      vecs[0] = '{256'd1000, 128'd7, 256'd142, 128'd6};
      vecs[1] = '{{128'd0, facA} * {128'd0, facB}, facB, {128'd0, facA}, 128'd0};
      vecs[2] = '{{DW{1'b1}}, 128'd1, {DW{1'b1}}, 128'd0};
      vecs[3] = '{256'd5, {VW{1'b1}}, 256'd0, 128'd5};
      vecs[4] = '{256'h1_0000_0000_0000_0000_0000_0000_0000_0005, 128'd0,
                  {DW{1'b1}}, 128'd5};
      vecs[5] = '{256'd12345, 128'd100, 256'd123, 128'd45};
      vecs[6] = '{256'd7, 128'd1000, 256'd0, 128'd7};
      vecs[7] = '{256'd100, 128'd10, 256'd10, 128'd0};

      bus.start = 1'b0;
      bus.ain   = '0;
      bus.bin   = '0;
      rst       = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("resetQuo",  bus.quo, '0);
      checkOutput("resetRem",  DW'(bus.rem), '0);
      checkOutput("resetBusy", DW'(bus.busy), '0);
      checkOutput("resetDone", DW'(bus.done), '0);
      checkOutput("resetErr",  DW'(bus.err), '0);
      rst = 1'b0;
      @(negedge clk);

      // Directed vector table
      for (int v = 0; v < 8; v++) begin
         applyStimulus(vecs[v].ain, vecs[v].bin, lat, busyE0, overlap);
`ifdef DIV256_DBZ_EN
         expErr = (vecs[v].bin == '0);
         expLat = (vecs[v].bin == '0) ? 1 : DW;
`else
         expErr = 1'b0;
         expLat = DW;
`endif
         checkOutput($sformatf("vec%0d.quo", v), bus.quo, vecs[v].quo);
         checkOutput($sformatf("vec%0d.rem", v), DW'(bus.rem), DW'(vecs[v].rem));
         checkOutput($sformatf("vec%0d.err", v), DW'(bus.err), DW'(expErr));
         checkOutput($sformatf("vec%0d.latency", v), DW'(lat), DW'(expLat));
         checkOutput($sformatf("vec%0d.busyAfterE0", v), DW'(busyE0), DW'(1));
         checkOutput($sformatf("vec%0d.busyDoneOverlap", v), DW'(overlap), DW'(0));
      end

      // Held start: exactly one result over 1000 cycles
      @(negedge clk);
      bus.ain   = 256'd1000;
      bus.bin   = 128'd7;
      bus.start = 1'b1;
      doneCount = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (bus.done) doneCount++;
      end
      checkOutput("heldStartDoneCount", DW'(doneCount), DW'(1));
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      applyStimulus(256'd1000, 128'd7, lat, busyE0, overlap);
      checkOutput("reStartLatency", DW'(lat), DW'(DW));
      checkOutput("reStartQuo", bus.quo, 256'd142);
      checkOutput("reStartRem", DW'(bus.rem), 256'd6);

      // Reset 100 cycles into RUN
      @(negedge clk);
      bus.ain   = {DW{1'b1}};
      bus.bin   = 128'd3;
      bus.start = 1'b1;
      repeat (101) @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("midResetQuo",  bus.quo, '0);
      checkOutput("midResetRem",  DW'(bus.rem), '0);
      checkOutput("midResetBusy", DW'(bus.busy), '0);
      checkOutput("midResetDone", DW'(bus.done), '0);
      checkOutput("midResetErr",  DW'(bus.err), '0);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      doneCount = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus.done) doneCount++;
      end
      checkOutput("midResetNoDone", DW'(doneCount), DW'(0));
      applyStimulus(256'd81, 128'd9, lat, busyE0, overlap);
      checkOutput("afterResetQuo", bus.quo, 256'd9);
      checkOutput("afterResetRem", DW'(bus.rem), 256'd0);
      checkOutput("afterResetLatency", DW'(lat), DW'(DW));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
